// File: rtl/ls_ctrl_pkg.sv
// ls_ctrl_pkg: op encodings, FSM state constants and dispatch helpers shared with the control unit
package ls_ctrl_pkg;
  localparam logic [2:0] LS_LB = 3'd0;
  localparam logic [2:0] LS_LH = 3'd1;
  localparam logic [2:0] LS_LW = 3'd2;
  localparam logic [2:0] LS_SB = 3'd4;
  localparam logic [2:0] LS_SH = 3'd5;
  localparam logic [2:0] LS_SW = 3'd6;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD_WB   = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_EXC       = 3'd4;
  function automatic logic ls_bad_op(input logic [2:0] op);
    return op == 3'd3 || op == 3'd7;
  endfunction
  function automatic logic ls_is_load(input logic [2:0] op);
    return !op[2];
  endfunction
  // First state after an accepted start: exceptions first, then SW straight to WRITE,
  // everything else needs the memory word first.
  function automatic logic [2:0] ls_dispatch(input logic [2:0] op, input logic [1:0] a);
    logic mis;
    mis = ((op == LS_LH || op == LS_SH) && a[0]) || ((op == LS_LW || op == LS_SW) && a != 2'b00);
    return (ls_bad_op(op) || mis) ? S_EXC : op == LS_SW ? S_WRITE : S_READ_WAIT;
  endfunction
endpackage

// File: rtl/ls_ctrl_if.sv
// ls_ctrl_if: request, memory and result signals between control unit, memory and ls_ctrl
interface ls_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] load_data;
  logic              bank_write;
  logic              busy;
  logic              done;
  logic              misalign;
  logic              bad_op;
  modport master (
    output start, op, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, load_data, bank_write, busy, done, misalign, bad_op
  );
  modport slave (
    input  start, op, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, load_data, bank_write, busy, done, misalign, bad_op
  );
endinterface

// File: rtl/ls_lane_unit.sv
// ls_lane_unit: little-endian lane extract with sign extension, and byte/half merge for stores
module ls_lane_unit
  import ls_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] bmask;
  logic [31:0] hmask;
  // Lane selection, sign extension and read-modify-write merge
  always_comb begin
    shifted     = word_i >> {addr_i, 3'b000};
    half        = addr_i[1] ? word_i[31:16] : word_i[15:0];
    bmask       = 32'h0000_00FF << {addr_i, 3'b000};
    hmask       = addr_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    load_data_o = op_i == LS_LB ? {{24{shifted[7]}}, shifted[7:0]} :
                  op_i == LS_LH ? {{16{half[15]}}, half} : word_i;
    merged_o    = op_i == LS_SB ? (word_i & ~bmask) | ({4{store_data_i[7:0]}} & bmask) :
                  op_i == LS_SH ? (word_i & ~hmask) | ({2{store_data_i[15:0]}} & hmask) : store_data_i;
  end
endmodule

// File: rtl/ls_ctrl.sv
// ls_ctrl: multi-cycle load/store sequencer with read-modify-write for sub-word stores
module ls_ctrl
  import ls_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 3
) (
  input logic         clk,
  input logic         reset,
  ls_ctrl_if.slave    bus
);
  logic [2:0]        state_q, state_d, op_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [DATA_W-1:0] sd_q, word_q, mem_wdata_q, load_data_q;
  logic              mem_wr_q, bank_write_q, busy_q, done_q, misalign_q, bad_op_q;
  logic [31:0]       lane_load, lane_merged;
  logic              last;
  assign last = cnt_q == 4'(MEM_LAT - 1);
  ls_lane_unit u_lane (
    .op_i(op_q), .addr_i(addr_q[1:0]), .word_i(word_q), .store_data_i(sd_q),
    .load_data_o(lane_load), .merged_o(lane_merged)
  );
  // Next state and read-latency counter
  always_comb begin
    state_d = state_q == S_IDLE      ? (bus.start ? ls_dispatch(bus.op, bus.addr[1:0]) : S_IDLE) :
              state_q == S_READ_WAIT ? (last ? (ls_is_load(op_q) ? S_LOAD_WB : S_WRITE) : S_READ_WAIT) :
              S_IDLE;
    cnt_d   = (state_q == S_READ_WAIT && !last) ? cnt_q + 4'd1 : 4'd0;
  end
  // State, request capture and registered outputs driven from the state being left
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      sd_q         <= '0;
      word_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      mem_wr_q     <= 1'b0;
      bank_write_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
      bad_op_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= state_d != S_IDLE;
      mem_wr_q     <= state_q == S_WRITE;
      bank_write_q <= state_q == S_LOAD_WB;
      done_q       <= state_q == S_WRITE || state_q == S_LOAD_WB || state_q == S_EXC;
      bad_op_q     <= state_q == S_EXC && ls_bad_op(op_q);
      misalign_q   <= state_q == S_EXC && !ls_bad_op(op_q);
      if (state_q == S_IDLE && bus.start) begin
        op_q       <= bus.op;
        addr_q     <= bus.addr;
        sd_q       <= bus.store_data;
        mem_addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
      end
      if (state_q == S_READ_WAIT && last) word_q <= bus.mem_rdata;
      if (state_q == S_LOAD_WB) load_data_q <= lane_load;
      if (state_q == S_WRITE) mem_wdata_q <= lane_merged;
    end
  end
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.load_data  = load_data_q;
  assign bus.bank_write = bank_write_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.misalign   = misalign_q;
  assign bus.bad_op     = bad_op_q;
endmodule

// File: tb/tb_ls_ctrl.sv
// tb_ls_ctrl: directed scoreboard bench for ls_ctrl with MEM_LAT=3
module tb_ls_ctrl;
  localparam int LAT = 3;
  typedef struct {
    int          cyc;
    logic        wr, bw, mis, bad;
    logic [31:0] ld, wd, ma;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  ls_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus();
  ls_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse and compares the whole response
  always @(negedge clk) begin
    if (reset) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("done_timeout", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if ((bus.mem_wr || bus.bank_write) && !bus.done) chk("strobe_without_done", 1, 0);
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
          chk("bank_write", 32'(bus.bank_write), 32'(e.bw));
          chk("misalign", 32'(bus.misalign), 32'(e.mis));
          chk("bad_op", 32'(bus.bad_op), 32'(e.bad));
          if (e.bw) chk("load_data", bus.load_data, e.ld);
          if (e.wr) chk("mem_wdata", bus.mem_wdata, e.wd);
          if (e.wr || e.bw) chk("mem_addr", bus.mem_addr, e.ma);
        end
      end
    end
  end

  task automatic push(input int c, input logic [31:0] a, input logic wr, bw, mis, bad,
                      input logic [31:0] ld, wd);
    exp_t e;
    e.cyc = c; e.wr = wr; e.bw = bw; e.mis = mis; e.bad = bad; e.ld = ld; e.wd = wd;
    e.ma = {a[31:2], 2'b00};
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // Issue one access at a negedge; sampling edge is the next posedge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, sd, rd, input int lat,
                       input logic wr, bw, mis, bad, input logic [31:0] ld, wd);
    push(cyc + 1 + lat, a, wr, bw, mis, bad, ld, wd);
    bus.start = 1'b1; bus.op = o; bus.addr = a; bus.store_data = sd; bus.mem_rdata = rd;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    if (lat > 1) chk("mem_addr_read", bus.mem_addr, {a[31:2], 2'b00});
    drain();
  endtask

  initial begin
    int c;
    bus.start = 1'b0; bus.op = '0; bus.addr = '0; bus.store_data = '0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_load_data", bus.load_data, 0);
    reset = 1'b1;
    @(negedge clk);
    issue(3'd2, 32'h100, 32'h0, 32'hDEADBEEF, LAT + 1, 0, 1, 0, 0, 32'hDEADBEEF, 0);
    issue(3'd0, 32'h103, 32'h0, 32'h80112233, LAT + 1, 0, 1, 0, 0, 32'hFFFFFF80, 0);
    issue(3'd1, 32'h102, 32'h0, 32'h80112233, LAT + 1, 0, 1, 0, 0, 32'hFFFF8011, 0);
    issue(3'd0, 32'h100, 32'h0, 32'h80112233, LAT + 1, 0, 1, 0, 0, 32'h00000033, 0);
    issue(3'd1, 32'h100, 32'h0, 32'h80112233, LAT + 1, 0, 1, 0, 0, 32'h00002233, 0);
    issue(3'd4, 32'h201, 32'hAA, 32'h11223344, LAT + 1, 1, 0, 0, 0, 0, 32'h1122AA44);
    issue(3'd4, 32'h203, 32'h55, 32'h11223344, LAT + 1, 1, 0, 0, 0, 0, 32'h55223344);
    issue(3'd5, 32'h202, 32'h1234CAFE, 32'h11223344, LAT + 1, 1, 0, 0, 0, 0, 32'hCAFE3344);
    issue(3'd6, 32'h200, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0, 0, 0, 32'hCAFEF00D);
    issue(3'd2, 32'h102, 32'h0, 32'h0, 1, 0, 0, 1, 0, 0, 0);
    issue(3'd5, 32'h201, 32'h0, 32'h0, 1, 0, 0, 1, 0, 0, 0);
    issue(3'd1, 32'h101, 32'h0, 32'h0, 1, 0, 0, 1, 0, 0, 0);
    issue(3'd3, 32'h100, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, 0);
    issue(3'd7, 32'h101, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, 0);
    // start held through a LW: one access, then a second accepted right after done
    c = cyc;
    push(c + 1 + LAT + 1, 32'h300, 0, 1, 0, 0, 32'h0BADF00D, 0);
    push(c + 1 + LAT + 1 + 1 + LAT + 1, 32'h300, 0, 1, 0, 0, 32'h0BADF00D, 0);
    bus.start = 1'b1; bus.op = 3'd2; bus.addr = 32'h300; bus.mem_rdata = 32'h0BADF00D;
    repeat (LAT + 3) @(negedge clk);
    bus.start = 1'b0;
    drain();
    // reset during READ_WAIT of an SH aborts with all outputs cleared
    bus.start = 1'b1; bus.op = 3'd5; bus.addr = 32'h202; bus.store_data = 32'h7777; bus.mem_rdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("sh_busy", 32'(bus.busy), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_mem_wr", 32'(bus.mem_wr), 0);
    chk("abort_bank_write", 32'(bus.bank_write), 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_mem_wdata", bus.mem_wdata, 0);
    chk("abort_load_data", bus.load_data, 0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    issue(3'd2, 32'h104, 32'h0, 32'h12345678, LAT + 1, 0, 1, 0, 0, 32'h12345678, 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
